// File: rtl/controle_ula.sv
// controle_ula: two-requester front end for an external combinational ALU.
// Round-robin arbitration, one-cycle execution, and a held response with an
// architectural {Z,C,S,O} flag register updated per operation class.
module controle_ula #(
  parameter int BITS_PALAVRA = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [4:0]              req0_op,
  input  logic [4:0]              req1_op,
  input  logic [BITS_PALAVRA-1:0] req0_a,
  input  logic [BITS_PALAVRA-1:0] req0_b,
  input  logic [BITS_PALAVRA-1:0] req1_a,
  input  logic [BITS_PALAVRA-1:0] req1_b,
  output logic [4:0]              ula_controle,
  output logic [BITS_PALAVRA-1:0] ula_a,
  output logic [BITS_PALAVRA-1:0] ula_b,
  input  logic [BITS_PALAVRA-1:0] ula_resultado,
  input  logic                    ula_z,
  input  logic                    ula_c,
  input  logic                    ula_s,
  input  logic                    ula_o,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic                    resp_id,
  output logic [BITS_PALAVRA-1:0] resp_resultado,
  output logic                    resp_erro,
  output logic [3:0]              flags
);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    EXEC   = 2'd1,
    RESP   = 2'd2
  } estado_t;

  // Operation classes, decide which flags an op is allowed to touch.
  localparam logic [2:0] CL_ARIT  = 3'd0;
  localparam logic [2:0] CL_SHIFT = 3'd1;
  localparam logic [2:0] CL_LOGIC = 3'd2;
  localparam logic [2:0] CL_CONST = 3'd3;
  localparam logic [2:0] CL_INDEF = 3'd4;

  // Undefined ops are steered to the ALU as a harmless constant op.
  localparam logic [4:0] OP_SEGURO = 5'b10000;

  function automatic logic [2:0] classe_op(input logic [4:0] op);
    case (op)
      5'b00000, 5'b00001, 5'b00011,
      5'b00100, 5'b00101, 5'b00110:          classe_op = CL_ARIT;
      5'b01000, 5'b01001:                    classe_op = CL_SHIFT;
      5'b10001, 5'b10010, 5'b10100, 5'b10101,
      5'b10110, 5'b10111, 5'b11000, 5'b11001,
      5'b11010, 5'b11011, 5'b11100, 5'b11101,
      5'b11110:                              classe_op = CL_LOGIC;
      5'b10000, 5'b10011, 5'b11111:          classe_op = CL_CONST;
      default:                               classe_op = CL_INDEF;
    endcase
  endfunction

  estado_t                 estado_q, estado_d;
  logic                    ultimo_q, ultimo_d;
  logic [4:0]              op_q, op_d;
  logic [BITS_PALAVRA-1:0] a_q, a_d;
  logic [BITS_PALAVRA-1:0] b_q, b_d;
  logic                    id_q, id_d;
  logic                    resp_id_q, resp_id_d;
  logic [BITS_PALAVRA-1:0] resp_resultado_q, resp_resultado_d;
  logic                    resp_erro_q, resp_erro_d;
  logic [3:0]              flags_q, flags_d;

  logic       grant;
  logic       aceita;
  logic [2:0] classe;

  // Round-robin grant: a lone request wins outright, a tie goes to the
  // requester that was not served last.
  always_comb begin
    grant = 1'b0;
    if (req_valid == 2'b11) begin
      grant = ~ultimo_q;
    end else begin
      grant = req_valid[1];
    end
  end

  assign aceita = (estado_q == OCIOSO) && (req_valid != 2'b00);
  assign classe = classe_op(op_q);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= OCIOSO;
    end else begin
      estado_q <= estado_d;
    end
  end

  // Next-state logic: accept -> one execute cycle -> hold response.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      OCIOSO:  if (aceita) estado_d = EXEC;
      EXEC:    estado_d = RESP;
      RESP:    if (resp_ready) estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
  end

  // Datapath registers: request latch, response and flag register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ultimo_q         <= 1'b1;
      op_q             <= '0;
      a_q              <= '0;
      b_q              <= '0;
      id_q             <= 1'b0;
      resp_id_q        <= 1'b0;
      resp_resultado_q <= '0;
      resp_erro_q      <= 1'b0;
      flags_q          <= 4'b0000;
    end else begin
      ultimo_q         <= ultimo_d;
      op_q             <= op_d;
      a_q              <= a_d;
      b_q              <= b_d;
      id_q             <= id_d;
      resp_id_q        <= resp_id_d;
      resp_resultado_q <= resp_resultado_d;
      resp_erro_q      <= resp_erro_d;
      flags_q          <= flags_d;
    end
  end

  // Next values for the datapath: latch on acceptance, capture in EXEC.
  always_comb begin
    ultimo_d         = ultimo_q;
    op_d             = op_q;
    a_d              = a_q;
    b_d              = b_q;
    id_d             = id_q;
    resp_id_d        = resp_id_q;
    resp_resultado_d = resp_resultado_q;
    resp_erro_d      = resp_erro_q;
    flags_d          = flags_q;

    if (aceita) begin
      ultimo_d = grant;
      id_d     = grant;
      op_d     = grant ? req1_op : req0_op;
      a_d      = grant ? req1_a  : req0_a;
      b_d      = grant ? req1_b  : req0_b;
    end

    if (estado_q == EXEC) begin
      resp_id_d = id_q;
      if (classe == CL_INDEF) begin
        resp_resultado_d = '0;
        resp_erro_d      = 1'b1;
      end else begin
        resp_resultado_d = ula_resultado;
        resp_erro_d      = 1'b0;
      end
      case (classe)
        CL_ARIT:  flags_d = {ula_z, ula_c, ula_s, ula_o};
        CL_SHIFT: flags_d = {ula_z, ula_c, ula_s, flags_q[0]};
        CL_LOGIC: flags_d = {ula_z, flags_q[2], ula_s, flags_q[0]};
        default:  flags_d = flags_q;
      endcase
    end
  end

  // Outputs: handshake strobes and the ALU drive, which is quiet outside EXEC.
  always_comb begin
    req_ready    = 2'b00;
    resp_valid   = 1'b0;
    ula_controle = '0;
    ula_a        = '0;
    ula_b        = '0;
    case (estado_q)
      OCIOSO: begin
        if (!reset) begin
          req_ready = req_valid & (grant ? 2'b10 : 2'b01);
        end
      end
      EXEC: begin
        ula_controle = (classe == CL_INDEF) ? OP_SEGURO : op_q;
        ula_a        = a_q;
        ula_b        = b_q;
      end
      RESP: begin
        resp_valid = 1'b1;
      end
      default: begin
        req_ready = 2'b00;
      end
    endcase
  end

  assign resp_id        = resp_id_q;
  assign resp_resultado = resp_resultado_q;
  assign resp_erro      = resp_erro_q;
  assign flags          = flags_q;

endmodule

// File: doc/controle_ula.md
CONTROLE_ULA -- requirements
Module: controle_ula

Interface
REQ-001 Parameter BITS_PALAVRA, default 16: operand, result and response data width in bits.
REQ-002 clock  input  1: single clock; all state updates on rising edge.
REQ-003 reset  input  1: asynchronous, active-high; forces reset state immediately, independent of clock.
REQ-004 req_valid  input  2: per-requester request strobe; bit i belongs to requester i.
REQ-005 req_ready  output  2: per-requester acceptance; a request is accepted when req_valid[i] and req_ready[i] are both 1 on a rising edge.
REQ-006 req0_op, req1_op  input  5 each: ALU operation code, using the same 5-bit encoding as the team ALU.
REQ-007 req0_a, req0_b, req1_a, req1_b  input  BITS_PALAVRA each: operands A and B.
REQ-008 ula_controle  output  5; ula_a, ula_b  output  BITS_PALAVRA each: drive the external combinational ALU.
REQ-009 ula_resultado  input  BITS_PALAVRA; ula_z, ula_c, ula_s, ula_o  input  1 each: ALU result and raw flags.
REQ-010 resp_valid  output  1; resp_ready  input  1; resp_id  output  1; resp_resultado  output  BITS_PALAVRA; resp_erro  output  1.
REQ-011 flags  output  4: architectural flag register {Z,C,S,O}, MSB = Z.

Function
REQ-012 The state machine SHALL have three states: OCIOSO, EXEC and RESP.
REQ-013 OCIOSO: req_ready SHALL be 1 only for the granted requester, and only while that requester's req_valid is 1; on acceptance, latch op, A, B and id, then go to EXEC.
REQ-014 Arbitration SHALL be round-robin: a single request is granted directly; with both requests active, grant the requester not granted last.
REQ-015 After reset, the last-granted pointer SHALL equal 1, so requester 0 wins the first tie.
REQ-016 EXEC SHALL last exactly one cycle: drive ula_controle, ula_a and ula_b from the latched values; capture ula_resultado into resp_resultado; update flags; go to RESP.
REQ-017 Outside EXEC, ula_controle, ula_a and ula_b SHALL be 0.
REQ-018 RESP: resp_valid SHALL be 1, with resp_id, resp_resultado and resp_erro held stable until resp_ready is 1 on a rising edge; then go to OCIOSO.
REQ-019 Latency: acceptance edge N -> resp_valid asserted from edge N+2; with resp_ready held at 1, the next acceptance can occur no earlier than edge N+3.
REQ-020 Flag update in EXEC SHALL follow the op class:
- arithmetic (00000, 00001, 00011, 00100, 00101, 00110): update Z, C, S and O;
- shift (01000, 01001): update Z, C and S; O unchanged;
- logic (10001, 10010, 10100, 10101, 10110 to 11110): update Z and S; C and O unchanged;
- constant/move (10000, 10011, 11111): no flag change.
REQ-021 Undefined op codes (00010, 00111, 01010 to 01111) SHALL:
- still pass through EXEC and RESP;
- return resp_resultado = 0 and resp_erro = 1;
- leave flags unchanged;
- drive ula_controle = 10000 during EXEC.
REQ-022 Request inputs SHALL be ignored in EXEC and RESP; req_ready SHALL be 00 in those states.
REQ-023 A requester that drops req_valid before acceptance SHALL lose its request without effect.
REQ-024 In RESP with resp_ready held at 0, the block SHALL hold indefinitely with no output change.

Reset
REQ-025 On reset assertion, the following SHALL take effect immediately:
- state = OCIOSO; req_ready = 00; resp_valid = 0; resp_id = 0; resp_resultado = 0; resp_erro = 0;
- flags = 0000; ula_* outputs = 0; last-granted pointer = 1.
REQ-026 Reset asserted during EXEC or RESP SHALL discard the in-flight operation; no response is produced after reset release.
REQ-027 The first acceptance SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-028 Reset, then req0 op 00000, A = 0x7FFF, B = 0x0001 -> resp_id 0, resp_resultado 0x8000, flags Z0 C0 S1 O1, resp_valid at acceptance+2.
REQ-029 Both requesters valid every cycle, resp_ready = 1 -> grants alternate 0,1,0,1 starting with requester 0.
REQ-030 After REQ-028, req1 op 10110, A = B = 0x1234 -> resp_resultado 0, flags Z1, S0, C0 and O1 retained.
REQ-031 req0 op 01010 -> resp_erro 1, resp_resultado 0, flags unchanged, ula_controle 10000 during EXEC.
REQ-032 resp_ready held at 0 for 5 cycles with req1 valid -> response held, req_ready stays 00, req1 accepted on the first edge in OCIOSO.
REQ-033 Reset asserted during EXEC of an op 00101 request -> all outputs at reset values immediately, no resp_valid after release, flags 0000.
